// File: rtl/plle2_drp_pkg.sv
// rtl/plle2_drp_pkg.sv - types, DRP address map and configuration table for the PLLE2 DRP sequencer
package plle2_drp_pkg;

   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] keep_mask;
      logic [15:0] data;
   } drp_entry_t;

   typedef enum logic [2:0] {
      S_IDLE, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_REL, S_LOCK_WAIT
   } state_t;

   localparam logic [6:0] CLKOUT5_REG1  = 7'h06;
   localparam logic [6:0] CLKOUT5_REG2  = 7'h07;
   localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
   localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
   localparam logic [6:0] CLKOUT1_REG1  = 7'h0A;
   localparam logic [6:0] CLKOUT1_REG2  = 7'h0B;
   localparam logic [6:0] CLKOUT2_REG1  = 7'h0C;
   localparam logic [6:0] CLKOUT2_REG2  = 7'h0D;
   localparam logic [6:0] CLKOUT3_REG1  = 7'h0E;
   localparam logic [6:0] CLKOUT3_REG2  = 7'h0F;
   localparam logic [6:0] CLKOUT4_REG1  = 7'h10;
   localparam logic [6:0] CLKOUT4_REG2  = 7'h11;
   localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
   localparam logic [6:0] CLKFBOUT_REG2 = 7'h15;
   localparam logic [6:0] LOCK_REG1     = 7'h18;
   localparam logic [6:0] LOCK_REG2     = 7'h19;
   localparam logic [6:0] LOCK_REG3     = 7'h1A;
   localparam logic [6:0] FILT_REG1     = 7'h4E;
   localparam logic [6:0] FILT_REG2     = 7'h4F;

   localparam int TBL_CFG  = 2;
   localparam int TBL_REGS = 8;

   // Readback-and-rewrite of address 0: leaves the PLL untouched for unpopulated slots.
   localparam drp_entry_t NOP_ENTRY = '{addr: 7'h00, keep_mask: 16'hFFFF, data: 16'h0000};

   localparam drp_entry_t CFG_TABLE [TBL_CFG][TBL_REGS] = '{
      '{ '{CLKOUT0_REG1,  16'h1000, 16'h0041},
         '{CLKOUT0_REG2,  16'hFC00, 16'h0000},
         '{CLKOUT1_REG1,  16'h1000, 16'h0082},
         '{CLKOUT1_REG2,  16'hFC00, 16'h0000},
         '{CLKFBOUT_REG1, 16'h1000, 16'h0145},
         '{CLKFBOUT_REG2, 16'hFC00, 16'h0000},
         '{LOCK_REG1,     16'hFC00, 16'h01E8},
         '{FILT_REG1,     16'h66FF, 16'h0900} },
      '{ '{CLKOUT0_REG1,  16'h1000, 16'h00C3},
         '{CLKOUT0_REG2,  16'hFC00, 16'h0080},
         '{CLKOUT1_REG1,  16'h1000, 16'h0104},
         '{CLKOUT1_REG2,  16'hFC00, 16'h0000},
         '{CLKFBOUT_REG1, 16'h1000, 16'h0186},
         '{CLKFBOUT_REG2, 16'hFC00, 16'h0000},
         '{LOCK_REG1,     16'hFC00, 16'h00FA},
         '{FILT_REG2,     16'h666F, 16'h0090} }
   };

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/plle2_drp_rom.sv
// rtl/plle2_drp_rom.sv - combinational (cfg, idx) -> DRP entry lookup
module plle2_drp_rom
   import plle2_drp_pkg::*;
#(
   parameter int N_CFG  = 2,
   parameter int N_REGS = 8
) (
   input  logic [width_of(N_CFG)-1:0]  cfg,
   input  logic [width_of(N_REGS)-1:0] idx,
   output drp_entry_t                  entry
);

   always_comb begin
      entry = NOP_ENTRY;
      for (int c = 0; c < TBL_CFG; c++) begin
         for (int r = 0; r < TBL_REGS; r++) begin
            if (32'(cfg) == c && 32'(idx) == r && c < N_CFG && r < N_REGS) begin
               entry = CFG_TABLE[c][r];
            end
         end
      end
   end

endmodule

// File: rtl/plle2_drp_sequencer.sv
// rtl/plle2_drp_sequencer.sv - PLLE2_ADV runtime reconfiguration through DRP read-modify-write
module plle2_drp_sequencer
   import plle2_drp_pkg::*;
#(
   parameter int N_CFG        = 2,
   parameter int N_REGS       = 8,
   parameter int DRDY_TIMEOUT = 15,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int RST_HOLD     = 4,
   localparam int CW          = width_of(N_CFG)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          I_START,
   input  logic [CW-1:0] I_CFG_SEL,
   output logic          O_BUSY,
   output logic          O_DONE,
   output logic          O_ERR,
   output logic [6:0]    O_DADDR,
   output logic [15:0]   O_DI,
   input  logic [15:0]   I_DO,
   output logic          O_DEN,
   output logic          O_DWE,
   input  logic          I_DRDY,
   output logic          O_PLL_RST,
   input  logic          I_LOCKED
);

   localparam int IW    = width_of(N_REGS);
   localparam int CNT_W = $clog2(max3(DRDY_TIMEOUT, LOCK_TIMEOUT, RST_HOLD) + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      sel_q, sel_d;
   logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic               den_q, den_d, dwe_q, dwe_d, pll_rst_q, pll_rst_d;
   logic [6:0]         daddr_q, daddr_d;
   logic [15:0]        di_q, di_d;
   logic               cfg_ok;
   drp_entry_t         entry;

   assign cfg_ok = 32'(I_CFG_SEL) < N_CFG;

   // Looked up with the next idx/sel so the address is ready in the cycle DEN rises.
   plle2_drp_rom #(.N_CFG(N_CFG), .N_REGS(N_REGS)) u_rom (
      .cfg   (sel_d),
      .idx   (idx_d),
      .entry (entry)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      err_d     = err_q;
      done_d    = 1'b0;
      pll_rst_d = pll_rst_q;
      case (state_q)
         S_IDLE: begin
            // A start landing on the DONE cycle belongs to the finishing sequence and is dropped.
            if (I_START && !done_q) begin
               if (cfg_ok) begin
                  sel_d     = I_CFG_SEL;
                  err_d     = 1'b0;
                  idx_d     = '0;
                  cnt_d     = '0;
                  busy_d    = 1'b1;
                  pll_rst_d = 1'b1;
                  state_d   = S_HOLD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
               cnt_d   = '0;
               state_d = S_RD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD: begin
            cnt_d   = '0;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (I_DRDY) begin
               state_d = S_WR;
            end else if (cnt_q == CNT_W'(DRDY_TIMEOUT)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR: begin
            cnt_d   = '0;
            state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (I_DRDY) begin
               if (idx_q == IW'(N_REGS - 1)) begin
                  pll_rst_d = 1'b0;
                  state_d   = S_REL;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_RD;
               end
            end else if (cnt_q == CNT_W'(DRDY_TIMEOUT)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REL: begin
            // The release cycle itself counts toward the lock budget.
            cnt_d   = CNT_W'(1);
            state_d = S_LOCK_WAIT;
         end
         S_LOCK_WAIT: begin
            if (I_LOCKED) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      den_d   = (state_d == S_RD) || (state_d == S_WR);
      dwe_d   = (state_d == S_WR);
      daddr_d = (state_d == S_RD) ? entry.addr : daddr_q;
      di_d    = (state_q == S_RD_WAIT && state_d == S_WR) ?
                ((I_DO & entry.keep_mask) | entry.data) : di_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sel_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         den_q     <= 1'b0;
         dwe_q     <= 1'b0;
         daddr_q   <= '0;
         di_q      <= '0;
         pll_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         den_q     <= den_d;
         dwe_q     <= dwe_d;
         daddr_q   <= daddr_d;
         di_q      <= di_d;
         pll_rst_q <= pll_rst_d;
      end
   end

   assign O_BUSY    = busy_q;
   assign O_DONE    = done_q;
   assign O_ERR     = err_q;
   assign O_DEN     = den_q;
   assign O_DWE     = dwe_q;
   assign O_DADDR   = daddr_q;
   assign O_DI      = di_q;
   assign O_PLL_RST = pll_rst_q;

endmodule

// File: tb/tb_plle2_drp_sequencer.sv
// tb/tb_plle2_drp_sequencer.sv - directed bench with DRP register model and LOCKED model
module tb_plle2_drp_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        I_START = 1'b0;
   logic [1:0]  I_CFG_SEL = 2'd0;
   logic        O_BUSY, O_DONE, O_ERR, O_DEN, O_DWE, O_PLL_RST;
   logic [6:0]  O_DADDR;
   logic [15:0] O_DI, I_DO;
   logic        I_DRDY;
   logic        I_LOCKED = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // {addr, data} written for cfg 0 over mem=FFFF and cfg 1 over mem=5A5A
   localparam logic [22:0] EXP0 [0:7] = '{{7'h08, 16'h1041}, {7'h09, 16'hFC00}, {7'h0A, 16'h1082}, {7'h0B, 16'hFC00},
                                         {7'h14, 16'h1145}, {7'h15, 16'hFC00}, {7'h18, 16'hFDE8}, {7'h4E, 16'h6FFF}};
   localparam logic [22:0] EXP1 [0:7] = '{{7'h08, 16'h10C3}, {7'h09, 16'h5880}, {7'h0A, 16'h1104}, {7'h0B, 16'h5800},
                                         {7'h14, 16'h1186}, {7'h15, 16'h5800}, {7'h18, 16'h58FA}, {7'h4F, 16'h42DA}};

   plle2_drp_sequencer #(
      .N_CFG(3), .N_REGS(8), .DRDY_TIMEOUT(15), .LOCK_TIMEOUT(100), .RST_HOLD(4)
   ) dut (
      .CLK(CLK), .RST(RST), .I_START(I_START), .I_CFG_SEL(I_CFG_SEL),
      .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR),
      .O_DADDR(O_DADDR), .O_DI(O_DI), .I_DO(I_DO), .O_DEN(O_DEN), .O_DWE(O_DWE),
      .I_DRDY(I_DRDY), .O_PLL_RST(O_PLL_RST), .I_LOCKED(I_LOCKED)
   );

   always #5 CLK = ~CLK;

   logic [15:0] mem [0:127];
   logic [6:0]  m_addr = 7'd0;
   logic [2:0]  den_sr = 3'b000;
   logic        drdy_en = 1'b1;
   logic        fill_req = 1'b0;
   logic [15:0] fill_val = 16'h0000;
   int          lock_delay = 5;
   int          lock_cnt = 0;
   int          cyc = 0, den_count = 0, wr_count = 0, done_count = 0;
   logic [22:0] wr_log [0:255];

   assign I_DRDY = den_sr[2] & drdy_en;
   assign I_DO   = mem[m_addr];

   always @(posedge CLK) begin
      cyc    <= cyc + 1;
      den_sr <= {den_sr[1:0], O_DEN};
      if (O_DONE) done_count <= done_count + 1;
      if (fill_req) begin
         for (int i = 0; i < 128; i++) mem[i] <= fill_val;
      end else if (O_DEN && O_DWE) begin
         mem[O_DADDR] <= O_DI;
      end
      if (O_DEN) begin
         den_count <= den_count + 1;
         m_addr    <= O_DADDR;
         if (O_DWE) begin
            wr_log[wr_count[7:0]] <= {O_DADDR, O_DI};
            wr_count <= wr_count + 1;
         end
      end
      if (O_PLL_RST) begin
         lock_cnt <= 0;
         I_LOCKED <= 1'b0;
      end else if (lock_delay >= 0 && lock_cnt >= lock_delay) begin
         I_LOCKED <= 1'b1;
      end else begin
         lock_cnt <= lock_cnt + 1;
      end
   end

   task automatic fill(input logic [15:0] v);
      @(negedge CLK);
      fill_val = v;
      fill_req = 1'b1;
      @(negedge CLK);
      fill_req = 1'b0;
   endtask

   task automatic start(input logic [1:0] sel);
      @(negedge CLK);
      I_CFG_SEL = sel;
      I_START   = 1'b1;
      @(negedge CLK);
      I_START   = 1'b0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge CLK);
         if (!O_BUSY) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if ({O_BUSY, O_DONE, O_ERR, O_DEN, O_DWE, O_DADDR, O_DI, O_PLL_RST} !== {5'b00000, 7'h00, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_values: got busy%b done%b err%b den%b dwe%b addr%h di%h rst%b, want all 0 and rst 1",
                  O_BUSY, O_DONE, O_ERR, O_DEN, O_DWE, O_DADDR, O_DI, O_PLL_RST);
      end
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({O_BUSY, O_PLL_RST} !== 2'b01) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b pll_rst=%b, want busy=0 pll_rst=1", O_BUSY, O_PLL_RST);
      end
   endtask

   task automatic test_config_write();
      int w0, n0, lock_c, done_c, bad_rst;
      fill(16'hFFFF);
      lock_delay = 5;
      w0 = wr_count; n0 = done_count;
      lock_c = -1; done_c = -1; bad_rst = 0;
      start(2'd0);
      for (int i = 0; i < 1000 && done_c < 0; i++) begin
         @(negedge CLK);
         if (O_DEN && !O_PLL_RST) bad_rst++;
         if (I_LOCKED && lock_c < 0) lock_c = cyc;
         if (O_DONE) done_c = cyc;
      end
      n_checks++;
      if (done_c < 0 || done_c != lock_c + 1) begin
         n_fail++;
         $display("FAIL cfg0_done_timing: done cycle %0d, locked cycle %0d, want done = locked+1", done_c, lock_c);
      end
      n_checks++;
      if (O_BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg0_busy_on_done: busy=%b want 0", O_BUSY);
      end
      n_checks++;
      if (bad_rst != 0) begin
         n_fail++;
         $display("FAIL cfg0_pll_rst_during_drp: %0d DEN cycles with pll_rst=0, want 0", bad_rst);
      end
      @(negedge CLK);
      n_checks++;
      if (wr_count - w0 != 8 || done_count - n0 != 1 || O_PLL_RST !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg0_counts: writes=%0d done=%0d pll_rst=%b, want 8 1 0", wr_count - w0, done_count - n0, O_PLL_RST);
      end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (wr_log[(w0 + k) & 255] !== EXP0[k]) begin
            n_fail++;
            $display("FAIL cfg0_write_%0d: got %h want %h", k, wr_log[(w0 + k) & 255], EXP0[k]);
         end
      end
   endtask

   task automatic test_drdy_timeout();
      int d0, n0, c_den, c_err;
      drdy_en = 1'b0;
      d0 = den_count; n0 = done_count;
      c_den = -1; c_err = -1;
      start(2'd0);
      for (int i = 0; i < 200 && c_err < 0; i++) begin
         @(negedge CLK);
         if (O_DEN && c_den < 0) c_den = cyc;
         if (O_ERR) c_err = cyc;
      end
      n_checks++;
      if (c_den < 0 || c_err - c_den != 17) begin
         n_fail++;
         $display("FAIL drdy_timeout_latency: err %0d cycles after DEN, want 17", c_err - c_den);
      end
      n_checks++;
      if ({O_BUSY, O_PLL_RST} !== 2'b01) begin
         n_fail++;
         $display("FAIL drdy_timeout_state: busy=%b pll_rst=%b, want 0 1", O_BUSY, O_PLL_RST);
      end
      repeat (5) @(negedge CLK);
      n_checks++;
      if (den_count - d0 != 1 || done_count - n0 != 0 || O_ERR !== 1'b1) begin
         n_fail++;
         $display("FAIL drdy_timeout_traffic: den=%0d done=%0d err=%b, want 1 0 1", den_count - d0, done_count - n0, O_ERR);
      end
      drdy_en = 1'b1;
   endtask

   task automatic test_lock_timeout();
      int n0, c_rel, c_err;
      bit ok;
      lock_delay = -1;
      n0 = done_count;
      c_rel = -1; c_err = -1;
      start(2'd1);
      for (int i = 0; i < 600 && c_err < 0; i++) begin
         @(negedge CLK);
         if (O_BUSY && !O_PLL_RST && c_rel < 0) c_rel = cyc;
         if (O_ERR && c_rel >= 0) c_err = cyc;
      end
      n_checks++;
      if (c_rel < 0 || c_err - c_rel != 101) begin
         n_fail++;
         $display("FAIL lock_timeout_latency: err %0d cycles after release (rel=%0d), want 101", c_err - c_rel, c_rel);
      end
      n_checks++;
      if ({O_BUSY, O_PLL_RST, O_DONE} !== 3'b000 || done_count != n0) begin
         n_fail++;
         $display("FAIL lock_timeout_state: busy=%b pll_rst=%b done=%b dones=%0d, want 0 0 0 0",
                  O_BUSY, O_PLL_RST, O_DONE, done_count - n0);
      end
      lock_delay = 5;
      start(2'd0);
      n_checks++;
      if ({O_ERR, O_BUSY} !== 2'b01) begin
         n_fail++;
         $display("FAIL err_cleared_by_start: err=%b busy=%b, want 0 1", O_ERR, O_BUSY);
      end
      wait_idle(1000, ok);
      n_checks++;
      if (!ok || O_DONE !== 1'b1 || O_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_after_lock_timeout: idle=%0d done=%b err=%b, want 1 1 0", ok, O_DONE, O_ERR);
      end
   endtask

   task automatic test_back_to_back();
      int d0, n0, w0;
      bit seen;
      fill(16'h5A5A);
      d0 = den_count; n0 = done_count; w0 = wr_count;
      seen = 1'b0;
      @(negedge CLK);
      I_CFG_SEL = 2'd1;
      I_START   = 1'b1;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge CLK);
         if (O_DONE) seen = 1'b1;
      end
      @(negedge CLK);
      I_START = 1'b0;
      n_checks++;
      if (!seen || O_BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done_start_ignored: done_seen=%0d busy=%b, want 1 0", seen, O_BUSY);
      end
      repeat (5) @(negedge CLK);
      n_checks++;
      if (den_count - d0 != 16 || done_count - n0 != 1 || wr_count - w0 != 8) begin
         n_fail++;
         $display("FAIL b2b_counts: den=%0d done=%0d writes=%0d, want 16 1 8", den_count - d0, done_count - n0, wr_count - w0);
      end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (wr_log[(w0 + k) & 255] !== EXP1[k]) begin
            n_fail++;
            $display("FAIL cfg1_write_%0d: got %h want %h", k, wr_log[(w0 + k) & 255], EXP1[k]);
         end
      end
   endtask

   task automatic test_reset_mid_sequence();
      int w0;
      bit found, ok;
      fill(16'h0000);
      found = 1'b0;
      start(2'd0);
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge CLK);
         if (O_DEN && O_DWE && O_DADDR == 7'h0B) found = 1'b1;
      end
      @(negedge CLK);
      RST = 1'b1;
      #1;
      n_checks++;
      if (!found || {O_BUSY, O_DONE, O_ERR, O_DEN, O_DWE, O_DADDR, O_DI, O_PLL_RST} !== {5'b00000, 7'h00, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_reset_values: found=%0d busy%b den%b dwe%b addr%h di%h rst%b, want reset values",
                  found, O_BUSY, O_DEN, O_DWE, O_DADDR, O_DI, O_PLL_RST);
      end
      @(negedge CLK);
      RST = 1'b0;
      w0 = wr_count;
      found = 1'b0;
      start(2'd0);
      for (int i = 0; i < 50 && !found; i++) begin
         if (O_DEN) found = 1'b1;
         else @(negedge CLK);
      end
      n_checks++;
      if (!found || O_DADDR !== 7'h08 || O_DWE !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_restart_first: den=%0d addr=%h dwe=%b, want 1 08 0", found, O_DADDR, O_DWE);
      end
      wait_idle(1000, ok);
      @(negedge CLK);
      n_checks++;
      if (!ok || wr_count - w0 != 8 || wr_log[w0 & 255] !== {7'h08, 16'h0041}) begin
         n_fail++;
         $display("FAIL mid_reset_rewrite: idle=%0d writes=%0d first=%h, want 1 8 0800041", ok, wr_count - w0, wr_log[w0 & 255]);
      end
   endtask

   task automatic test_invalid_cfg();
      int d0, busy_seen;
      d0 = den_count;
      busy_seen = 0;
      start(2'd3);
      n_checks++;
      if ({O_ERR, O_BUSY} !== 2'b10) begin
         n_fail++;
         $display("FAIL invalid_cfg_err: err=%b busy=%b, want 1 0", O_ERR, O_BUSY);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (O_BUSY) busy_seen++;
      end
      n_checks++;
      if (busy_seen != 0 || den_count != d0 || O_PLL_RST !== 1'b0) begin
         n_fail++;
         $display("FAIL invalid_cfg_quiet: busy_cycles=%0d den=%0d pll_rst=%b, want 0 0 0", busy_seen, den_count - d0, O_PLL_RST);
      end
   endtask

   initial begin
      test_reset();
      test_config_write();
      test_drdy_timeout();
      test_lock_timeout();
      test_back_to_back();
      test_reset_mid_sequence();
      test_invalid_cfg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
